// File: rtl/serdesphy_pma_pwr_seq_if.sv
// PMA control/status bundle between the power sequencer and the analog PMA / PCS layer.
// master = sequencer side, slave = PMA/PCS side.
interface serdesphy_pma_pwr_seq_if;
  logic       phy_en;
  logic       pll_lock_raw;
  logic       pll_vco_ok;
  logic       pll_cp_ok;
  logic       serializer_ready;
  logic       deserializer_ready;
  logic       analog_iso_n;
  logic       analog_reset_n;
  logic       pll_iso_n;
  logic       pll_enable;
  logic       pll_reset_n;
  logic       serializer_enable;
  logic       serializer_reset_n;
  logic       deserializer_enable;
  logic       deserializer_reset_n;
  logic       phy_ready;
  logic       pll_locked;
  logic       lock_lost;
  logic       seq_error;
  logic [3:0] seq_state;

  modport master (
    input  phy_en, pll_lock_raw, pll_vco_ok, pll_cp_ok, serializer_ready, deserializer_ready,
    output analog_iso_n, analog_reset_n, pll_iso_n, pll_enable, pll_reset_n,
           serializer_enable, serializer_reset_n, deserializer_enable, deserializer_reset_n,
           phy_ready, pll_locked, lock_lost, seq_error, seq_state
  );

  modport slave (
    output phy_en, pll_lock_raw, pll_vco_ok, pll_cp_ok, serializer_ready, deserializer_ready,
    input  analog_iso_n, analog_reset_n, pll_iso_n, pll_enable, pll_reset_n,
           serializer_enable, serializer_reset_n, deserializer_enable, deserializer_reset_n,
           phy_ready, pll_locked, lock_lost, seq_error, seq_state
  );
endinterface

// File: rtl/serdesphy_pma_pwr_seq.sv
// SerDes PMA power-up sequencer: isolation/reset release, PLL lock qualification, datapath
// bring-up, lock-loss relock and error reporting. All outputs are registered.
module serdesphy_pma_pwr_seq #(
  parameter int unsigned ISO_WAIT     = 24,
  parameter int unsigned RST_WAIT     = 48,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 2400,
  parameter int unsigned MAX_RELOCK   = 3,
  parameter int unsigned CNT_W        = 12
) (
  input logic                    clk_ref_24m,
  input logic                    rst,
  serdesphy_pma_pwr_seq_if.master pma_io
);

  localparam int unsigned StW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RlW = (MAX_RELOCK > 0) ? $clog2(MAX_RELOCK + 1) : 1;

  localparam logic [CNT_W-1:0] IsoLast    = CNT_W'(ISO_WAIT - 1);
  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_WAIT - 1);
  localparam logic [CNT_W-1:0] ToLast     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [StW-1:0]   StableLast = StW'(LOCK_STABLE - 1);
  localparam logic [RlW-1:0]   RlMax      = RlW'(MAX_RELOCK);

  typedef enum logic [3:0] {
    StOff     = 4'd0,
    StIsoRel  = 4'd1,
    StArstRel = 4'd2,
    StPllEn   = 4'd3,
    StPllLock = 4'd4,
    StDpEn    = 4'd5,
    StDpRel   = 4'd6,
    StReady   = 4'd7,
    StError   = 4'd8
  } state_e;

  typedef struct packed {
    logic analog_iso_n;
    logic analog_reset_n;
    logic pll_iso_n;
    logic pll_enable;
    logic pll_reset_n;
    logic pll_locked;
    logic serializer_enable;
    logic serializer_reset_n;
    logic deserializer_enable;
    logic deserializer_reset_n;
    logic phy_ready;
    logic seq_error;
  } outs_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [StW-1:0]   stable_q, stable_d;
  logic [RlW-1:0]   relock_q, relock_d;
  logic             lost_q, lost_d;
  outs_t            outs_q, outs_d;
  logic             lock_ok;

  assign lock_ok = pma_io.pll_lock_raw & pma_io.pll_vco_ok & pma_io.pll_cp_ok;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + CNT_W'(1);
    stable_d = stable_q;
    relock_d = relock_q;
    lost_d   = 1'b0;

    case (state_q)
      StOff:     if (pma_io.phy_en) state_d = StIsoRel;
      StIsoRel:  if (timer_q == IsoLast) state_d = StArstRel;
      StArstRel: if (timer_q == RstLast) state_d = StPllEn;
      StPllEn:   if (timer_q == RstLast) state_d = StPllLock;
      StPllLock: begin
        if (lock_ok) begin
          if (stable_q == StableLast) state_d = StDpEn;
          else stable_d = stable_q + StW'(1);
        end else begin
          stable_d = '0;
        end
        // Qualified lock wins over a timeout landing on the same cycle.
        if (state_d == StPllLock && timer_q == ToLast) state_d = StError;
      end
      StDpEn:    if (timer_q == RstLast) state_d = StDpRel;
      StDpRel: begin
        if (pma_io.serializer_ready && pma_io.deserializer_ready) state_d = StReady;
        else if (timer_q == ToLast) state_d = StError;
      end
      StReady: begin
        // Stable counter doubles as the consecutive-loss counter here.
        if (!pma_io.pll_lock_raw) begin
          if (stable_q == StableLast) begin
            lost_d   = 1'b1;
            relock_d = (relock_q == RlMax) ? relock_q : relock_q + RlW'(1);
            state_d  = (relock_q == RlMax) ? StError : StPllEn;
          end else begin
            stable_d = stable_q + StW'(1);
          end
        end else begin
          stable_d = '0;
        end
      end
      StError:   if (!pma_io.phy_en) state_d = StOff;
      default:   state_d = StOff;
    endcase

    if (state_q != StError && !pma_io.phy_en) begin
      state_d = StOff;
      lost_d  = 1'b0;
    end

    if (state_d != state_q) begin
      timer_d  = '0;
      stable_d = '0;
    end
    if (state_d == StOff) relock_d = '0;
  end

  // Moore decode of the next state so outputs change on the edge that enters a state.
  always_comb begin
    outs_d = '0;
    outs_d.analog_iso_n = state_d inside {StIsoRel, StArstRel, StPllEn, StPllLock, StDpEn,
                                          StDpRel, StReady};
    outs_d.pll_iso_n            = outs_d.analog_iso_n;
    outs_d.analog_reset_n       = state_d inside {StArstRel, StPllEn, StPllLock, StDpEn,
                                                  StDpRel, StReady};
    outs_d.pll_enable           = state_d inside {StPllEn, StPllLock, StDpEn, StDpRel, StReady};
    outs_d.pll_reset_n          = state_d inside {StPllLock, StDpEn, StDpRel, StReady};
    outs_d.pll_locked           = state_d inside {StDpEn, StDpRel, StReady};
    outs_d.serializer_enable    = outs_d.pll_locked;
    outs_d.deserializer_enable  = outs_d.pll_locked;
    outs_d.serializer_reset_n   = state_d inside {StDpRel, StReady};
    outs_d.deserializer_reset_n = outs_d.serializer_reset_n;
    outs_d.phy_ready            = (state_d == StReady);
    outs_d.seq_error            = (state_d == StError);
  end

  always_ff @(posedge clk_ref_24m) begin
    if (rst) begin
      state_q  <= StOff;
      timer_q  <= '0;
      stable_q <= '0;
      relock_q <= '0;
      lost_q   <= 1'b0;
      outs_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      stable_q <= stable_d;
      relock_q <= relock_d;
      lost_q   <= lost_d;
      outs_q   <= outs_d;
    end
  end

  assign pma_io.analog_iso_n         = outs_q.analog_iso_n;
  assign pma_io.analog_reset_n       = outs_q.analog_reset_n;
  assign pma_io.pll_iso_n            = outs_q.pll_iso_n;
  assign pma_io.pll_enable           = outs_q.pll_enable;
  assign pma_io.pll_reset_n          = outs_q.pll_reset_n;
  assign pma_io.serializer_enable    = outs_q.serializer_enable;
  assign pma_io.serializer_reset_n   = outs_q.serializer_reset_n;
  assign pma_io.deserializer_enable  = outs_q.deserializer_enable;
  assign pma_io.deserializer_reset_n = outs_q.deserializer_reset_n;
  assign pma_io.phy_ready            = outs_q.phy_ready;
  assign pma_io.pll_locked           = outs_q.pll_locked;
  assign pma_io.seq_error            = outs_q.seq_error;
  assign pma_io.lock_lost            = lost_q;
  assign pma_io.seq_state            = state_q;

endmodule

// File: tb/tb_serdesphy_pma_pwr_seq.sv
// Bench for serdesphy_pma_pwr_seq: directed bring-up scenarios plus randomized input
// segments, every cycle compared against a behavioural state/dwell model.
module tb_serdesphy_pma_pwr_seq;
  localparam int ISO_WAIT     = 24;
  localparam int RST_WAIT     = 48;
  localparam int LOCK_STABLE  = 16;
  localparam int LOCK_TIMEOUT = 2400;
  localparam int MAX_RELOCK   = 3;

  logic clk_ref_24m = 1'b0;
  logic rst         = 1'b1;

  serdesphy_pma_pwr_seq_if pma_if ();

  serdesphy_pma_pwr_seq #(
    .ISO_WAIT    (ISO_WAIT),
    .RST_WAIT    (RST_WAIT),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RELOCK  (MAX_RELOCK),
    .CNT_W       (12)
  ) dut (
    .clk_ref_24m(clk_ref_24m),
    .rst        (rst),
    .pma_io     (pma_if)
  );

  always #5 clk_ref_24m = ~clk_ref_24m;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: current phase, cycles spent in it, current run length, relock count.
  int m_st  = 0;
  int m_cyc = 1;
  int m_run = 0;
  int m_rl  = 0;
  bit m_lost = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
  endtask

  // Each phase keeps the previous phase's levels; ERROR shows only seq_error.
  function automatic logic [11:0] exp_outs(input int st);
    logic [11:0] v;
    bit up;
    up    = (st >= 1 && st <= 7);
    v[11] = up;
    v[10] = up && st >= 2;
    v[9]  = up;
    v[8]  = up && st >= 3;
    v[7]  = up && st >= 4;
    v[6]  = up && st >= 5;
    v[5]  = up && st >= 5;
    v[4]  = up && st >= 6;
    v[3]  = up && st >= 5;
    v[2]  = up && st >= 6;
    v[1]  = (st == 7);
    v[0]  = (st == 8);
    return v;
  endfunction

  function automatic logic [11:0] got_outs();
    return {pma_if.analog_iso_n, pma_if.analog_reset_n, pma_if.pll_iso_n, pma_if.pll_enable,
            pma_if.pll_reset_n, pma_if.pll_locked, pma_if.serializer_enable,
            pma_if.serializer_reset_n, pma_if.deserializer_enable,
            pma_if.deserializer_reset_n, pma_if.phy_ready, pma_if.seq_error};
  endfunction

  task automatic model_step();
    int nst;
    bit lost;
    bit en, lk, good, rdy;
    en   = pma_if.phy_en;
    lk   = pma_if.pll_lock_raw;
    good = pma_if.pll_lock_raw && pma_if.pll_vco_ok && pma_if.pll_cp_ok;
    rdy  = pma_if.serializer_ready && pma_if.deserializer_ready;
    nst  = m_st;
    lost = 1'b0;
    if (rst) begin
      m_st = 0; m_cyc = 1; m_run = 0; m_rl = 0; m_lost = 1'b0;
    end else begin
      if (m_st != 8 && !en) nst = 0;
      else begin
        case (m_st)
          0: if (en) nst = 1;
          1: if (m_cyc == ISO_WAIT) nst = 2;
          2, 3, 5: if (m_cyc == RST_WAIT) nst = m_st + 1;
          4: begin
            m_run = good ? m_run + 1 : 0;
            if (m_run == LOCK_STABLE) nst = 5;
            else if (m_cyc == LOCK_TIMEOUT) nst = 8;
          end
          6: if (rdy) nst = 7; else if (m_cyc == LOCK_TIMEOUT) nst = 8;
          7: begin
            m_run = lk ? 0 : m_run + 1;
            if (m_run == LOCK_STABLE) begin
              lost = 1'b1;
              nst  = (m_rl >= MAX_RELOCK) ? 8 : 3;
              if (m_rl < MAX_RELOCK) m_rl++;
            end
          end
          8: if (!en) nst = 0;
          default: nst = 0;
        endcase
      end
      if (nst == 0) m_rl = 0;
      if (nst != m_st) begin
        m_cyc = 1;
        m_run = 0;
      end else begin
        m_cyc++;
      end
      m_st   = nst;
      m_lost = lost;
    end
  endtask

  task automatic tick();
    @(posedge clk_ref_24m);
    model_step();
    #1;
    chk("outputs", got_outs(), exp_outs(m_st));
    chk("seq_state", pma_if.seq_state, m_st);
    chk("lock_lost", pma_if.lock_lost, m_lost);
  endtask

  task automatic set_in(input bit en, input bit lk, input bit vco, input bit cp, input bit sr,
                        input bit dr);
    pma_if.phy_en             = en;
    pma_if.pll_lock_raw       = lk;
    pma_if.pll_vco_ok         = vco;
    pma_if.pll_cp_ok          = cp;
    pma_if.serializer_ready   = sr;
    pma_if.deserializer_ready = dr;
  endtask

  task automatic wait_state(input int st, input int budget, output int n);
    n = 0;
    while (pma_if.seq_state != st && n < budget) begin
      tick();
      n++;
    end
    if (pma_if.seq_state != st) chk("wait_state_timeout", pma_if.seq_state, st);
  endtask

  initial begin
    int n;
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_outs", got_outs(), 12'h000);
    chk("reset_state", pma_if.seq_state, 0);

    // Nominal bring-up with everything healthy.
    set_in(1, 1, 1, 1, 1, 1);
    wait_state(7, 400, n);
    chk("bringup_cycles", n, 186);
    chk("bringup_outs", got_outs(), 12'hFFE);

    // Short glitch in READY must be ignored.
    pma_if.pll_lock_raw = 1'b0;
    repeat (LOCK_STABLE - 1) tick();
    pma_if.pll_lock_raw = 1'b1;
    tick();
    chk("glitch_state", pma_if.seq_state, 7);

    // Three relocks, the fourth loss lands in ERROR.
    for (int k = 0; k < 4; k++) begin
      pma_if.pll_lock_raw = 1'b0;
      repeat (LOCK_STABLE) tick();
      chk("loss_pulse", pma_if.lock_lost, 1);
      chk("loss_state", pma_if.seq_state, (k < 3) ? 3 : 8);
      chk("loss_ready", pma_if.phy_ready, 0);
      pma_if.pll_lock_raw = 1'b1;
      tick();
      chk("loss_pulse_len", pma_if.lock_lost, 0);
      if (k < 3) wait_state(7, 300, n);
    end
    pma_if.phy_en = 1'b0;
    tick();
    chk("error_exit", pma_if.seq_state, 0);

    // Lock timeout.
    set_in(1, 0, 1, 1, 1, 1);
    wait_state(4, 200, n);
    wait_state(8, 3000, n);
    chk("timeout_cycles", n, LOCK_TIMEOUT);
    chk("timeout_outs", got_outs(), 12'h001);
    pma_if.phy_en = 1'b0;
    tick();
    chk("timeout_exit", pma_if.seq_state, 0);

    // Lock chatter: 15 good, 1 bad, then good.
    set_in(1, 0, 1, 1, 1, 1);
    wait_state(4, 200, n);
    pma_if.pll_lock_raw = 1'b1;
    repeat (LOCK_STABLE - 1) tick();
    pma_if.pll_lock_raw = 1'b0;
    tick();
    pma_if.pll_lock_raw = 1'b1;
    wait_state(5, 100, n);
    chk("chatter_cycles", n, LOCK_STABLE);

    // Abort in DP_REL, then full re-bring-up.
    pma_if.serializer_ready = 1'b0;
    wait_state(6, 200, n);
    tick();
    tick();
    pma_if.phy_en = 1'b0;
    tick();
    chk("abort_outs", got_outs(), 12'h000);
    chk("abort_state", pma_if.seq_state, 0);
    set_in(1, 1, 1, 1, 1, 1);
    wait_state(7, 400, n);
    chk("rebringup_cycles", n, 186);

    // Synchronous reset mid PLL_LOCK.
    pma_if.phy_en = 1'b0;
    tick();
    set_in(1, 0, 1, 1, 1, 1);
    wait_state(4, 200, n);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("midreset_outs", got_outs(), 12'h000);
    chk("midreset_state", pma_if.seq_state, 0);
    rst = 1'b0;

    // Randomized segments.
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      int mode;
      len  = $urandom_range(1, 80);
      mode = $urandom_range(0, 3);
      pma_if.phy_en = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      for (int c = 0; c < len; c++) begin
        pma_if.pll_lock_raw       = (mode == 1) ? 1'b0 :
                                    (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        pma_if.pll_vco_ok         = ($urandom_range(0, 40) != 0);
        pma_if.pll_cp_ok          = ($urandom_range(0, 40) != 0);
        pma_if.serializer_ready   = ($urandom_range(0, 3) != 0);
        pma_if.deserializer_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
